// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic detector conditioning path.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RISE_CHK = 2'd1,
        ACTIVE   = 2'd2,
        FALL_CHK = 2'd3
    } sensor_state_t;

    localparam int STREET_A = 0;
    localparam int STREET_B = 1;

    // Counter widths derived from $clog2 collapse to 0 for tiny limits.
    function automatic int min1(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/traffic_sensor_channel.sv
// One detector channel: synchroniser, debounce FSM, presence hold timer and
// saturating arrival counter.
module traffic_sensor_channel
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int HOLD     = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det,
    input  logic             clr_cnt,
    output logic             present,
    output logic [CNT_W-1:0] cnt
);

    localparam int DB_W   = min1($clog2(DEBOUNCE + 1));
    localparam int HOLD_W = min1($clog2(HOLD + 1));

    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              sync_p0;
    logic              sync_p1;
    sensor_state_t     state;
    sensor_state_t     state_nxt;
    logic [DB_W-1:0]   dcnt;
    logic [DB_W-1:0]   dcnt_nxt;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;
    logic              arrive;
    logic              arrive_p;
    logic              present_nxt;

    // Stage p0/p1: two-flop synchroniser for the asynchronous detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= det;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dcnt     <= '0;
            hold     <= '0;
            arrive_p <= 1'b0;
        end else begin
            state    <= state_nxt;
            dcnt     <= dcnt_nxt;
            hold     <= hold_nxt;
            arrive_p <= arrive;
        end
    end

    // The sample that moves the FSM into a check state counts as the first
    // stable sample, so dcnt holds the number of stable samples seen so far.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        hold_nxt  = hold;
        arrive    = 1'b0;
        if (hold != '0) begin
            hold_nxt = hold - 1'b1;
        end
        case (state)
            IDLE: begin
                if (sync_p1) begin
                    state_nxt = RISE_CHK;
                    dcnt_nxt  = DB_ONE;
                end
            end
            RISE_CHK: begin
                if (!sync_p1) begin
                    state_nxt = IDLE;
                end else if (dcnt >= DB_LAST) begin
                    state_nxt = ACTIVE;
                    arrive    = 1'b1;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            ACTIVE: begin
                if (!sync_p1) begin
                    state_nxt = FALL_CHK;
                    dcnt_nxt  = DB_ONE;
                end
            end
            FALL_CHK: begin
                if (sync_p1) begin
                    state_nxt = ACTIVE;
                end else if (dcnt >= DB_LAST) begin
                    state_nxt = IDLE;
                    hold_nxt  = HOLD_LOAD;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign present_nxt = (state == ACTIVE) || (state == FALL_CHK) || (hold != '0);

    // Stage p2: presence register and counter, aligned one cycle after the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            present <= 1'b0;
        end else begin
            present <= present_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= arrive_p ? CNT_ONE : '0;
        end else if (arrive_p && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Two independent detector channels feeding Ta/Tb of the light controller.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int HOLD     = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det_a,
    input  logic             det_b,
    input  logic             clr_cnt,
    output logic             Ta,
    output logic             Tb,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic [1:0]       det_v;
    logic [1:0]       present_v;
    logic [CNT_W-1:0] cnt_v [2];

    assign det_v[STREET_A] = det_a;
    assign det_v[STREET_B] = det_b;

    traffic_sensor_channel #(
        .DEBOUNCE (DEBOUNCE),
        .HOLD     (HOLD),
        .CNT_W    (CNT_W)
    ) u_chan_a (
        .clk     (clk),
        .rst     (rst),
        .det     (det_v[STREET_A]),
        .clr_cnt (clr_cnt),
        .present (present_v[STREET_A]),
        .cnt     (cnt_v[STREET_A])
    );

    traffic_sensor_channel #(
        .DEBOUNCE (DEBOUNCE),
        .HOLD     (HOLD),
        .CNT_W    (CNT_W)
    ) u_chan_b (
        .clk     (clk),
        .rst     (rst),
        .det     (det_v[STREET_B]),
        .clr_cnt (clr_cnt),
        .present (present_v[STREET_B]),
        .cnt     (cnt_v[STREET_B])
    );

    assign Ta    = present_v[STREET_A];
    assign Tb    = present_v[STREET_B];
    assign cnt_a = cnt_v[STREET_A];
    assign cnt_b = cnt_v[STREET_B];

endmodule
